// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts synchronised rising edges over a gate window.
// Build option: define RO_FREQ_METER_SATURATE_EN to saturate the edge counter; otherwise it wraps.
module ro_freq_meter #(
    parameter int CHANNELS    = 4,
    parameter int COUNT_W     = 16,
    parameter int GATE_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] ro_in,
    output logic [CHANNELS-1:0] ro_ena,
    input  logic [SEL_W-1:0]    chan_sel,
    input  logic [GATE_W-1:0]   gate_len,
    input  logic                start,
    input  logic                continuous,
    input  logic                shift,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [COUNT_W-1:0]  count,
    output logic                sdo
);

    localparam int SETTLE_CYC = SYNC_STAGES + 1;
    localparam int TMR_W = (GATE_W > $clog2(SETTLE_CYC + 1)) ? GATE_W : $clog2(SETTLE_CYC + 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE} state_t;

    state_t               state_reg, state_next;
    logic [SEL_W-1:0]     sel_reg, sel_next;
    logic [GATE_W-1:0]    gate_reg, gate_next;
    logic [TMR_W-1:0]     tmr_reg, tmr_next;
    logic [COUNT_W-1:0]   cnt_reg, cnt_next;
    logic                 acc_ovf_reg, acc_ovf_next;
    logic [COUNT_W-1:0]   count_reg, count_next;
    logic                 ovf_reg, ovf_next;
    logic                 done_reg, done_next;
    logic [COUNT_W-1:0]   shreg_reg, shreg_next;
    logic [CHANNELS-1:0]  prev_reg;

    logic [CHANNELS-1:0]  ro_sync;
    logic [CHANNELS-1:0]  edge_vec;
    logic                 ro_edge;
    logic                 cnt_at_max;
    logic [COUNT_W-1:0]   cnt_inc;
    logic [COUNT_W-1:0]   cnt_upd;
    logic                 acc_ovf_upd;
    logic                 latch;

    // One independent synchroniser chain per ring input.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], ro_in[gi]};
                end
            end
            assign ro_sync[gi] = chain_reg[SYNC_STAGES-1];
            assign ro_ena[gi]  = busy && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign edge_vec    = ro_sync & ~prev_reg;
    assign ro_edge     = edge_vec[sel_reg];
    assign cnt_at_max  = (cnt_reg == CNT_MAX);
`ifdef RO_FREQ_METER_SATURATE_EN
    assign cnt_inc     = cnt_at_max ? cnt_reg : cnt_reg + 1'b1;
`else
    assign cnt_inc     = cnt_reg + 1'b1;
`endif
    assign cnt_upd     = ro_edge ? cnt_inc : cnt_reg;
    assign acc_ovf_upd = acc_ovf_reg | (ro_edge & cnt_at_max);

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign overflow = ovf_reg;
    assign count    = count_reg;
    assign sdo      = shreg_reg[COUNT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        gate_next    = gate_reg;
        tmr_next     = tmr_reg;
        cnt_next     = cnt_reg;
        acc_ovf_next = acc_ovf_reg;
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        done_next    = done_reg;
        latch        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sel_next     = (int'(chan_sel) >= CHANNELS) ? '0 : chan_sel;
                    gate_next    = (gate_len == '0) ? GATE_W'(1) : gate_len;
                    tmr_next     = TMR_W'(SETTLE_CYC - 1);
                    cnt_next     = '0;
                    acc_ovf_next = 1'b0;
                    done_next    = 1'b0;
                    state_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (tmr_reg == '0) begin
                    tmr_next   = TMR_W'(gate_reg) - TMR_W'(1);
                    state_next = GATE;
                end else begin
                    tmr_next = tmr_reg - TMR_W'(1);
                end
            end
            GATE: begin
                cnt_next     = cnt_upd;
                acc_ovf_next = acc_ovf_upd;
                if (tmr_reg == '0) begin
                    // Final window cycle: the edge seen this cycle is part of the result.
                    latch      = 1'b1;
                    count_next = cnt_upd;
                    ovf_next   = acc_ovf_upd;
                    done_next  = 1'b1;
                    if (continuous) begin
                        cnt_next     = '0;
                        acc_ovf_next = 1'b0;
                        tmr_next     = TMR_W'(gate_reg) - TMR_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    tmr_next = tmr_reg - TMR_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A reload on latch wins over a coincident shift request.
    always_comb begin
        shreg_next = shreg_reg;
        if (latch) begin
            shreg_next = cnt_upd;
        end else if (shift) begin
            shreg_next = {shreg_reg[COUNT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg     <= '0;
            gate_reg    <= '0;
            tmr_reg     <= '0;
            cnt_reg     <= '0;
            acc_ovf_reg <= 1'b0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            done_reg    <= 1'b0;
            shreg_reg   <= '0;
            prev_reg    <= '0;
        end else begin
            sel_reg     <= sel_next;
            gate_reg    <= gate_next;
            tmr_reg     <= tmr_next;
            cnt_reg     <= cnt_next;
            acc_ovf_reg <= acc_ovf_next;
            count_reg   <= count_next;
            ovf_reg     <= ovf_next;
            done_reg    <= done_next;
            shreg_reg   <= shreg_next;
            prev_reg    <= ro_sync;
        end
    end

endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed bench for ro_freq_meter: a 16-bit instance and a 4-bit instance share all stimulus.
module tb_ro_freq_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ro_in;
    logic [1:0]  chan_sel;
    logic [11:0] gate_len;
    logic        start, continuous, shift;

    logic [3:0]  ro_ena_a, ro_ena_b;
    logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b, sdo_a, sdo_b;
    logic [15:0] count_a;
    logic [3:0]  count_b;

    int total = 0;
    int bad   = 0;
    int per[4] = '{0, 0, 0, 0};
    int ph[4]  = '{0, 0, 0, 0};

    typedef struct {
        int         ch;
        int         g;
        int         p[4];
        int         exp_cnt;
        int         exp_lat;
        logic [3:0] exp_ena;
    } vec_t;

    vec_t vecs[5];

    ro_freq_meter #(.CHANNELS(4), .COUNT_W(16), .GATE_W(12), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_ena(ro_ena_a), .chan_sel(chan_sel),
        .gate_len(gate_len), .start(start), .continuous(continuous), .shift(shift),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .count(count_a), .sdo(sdo_a)
    );

    ro_freq_meter #(.CHANNELS(4), .COUNT_W(4), .GATE_W(12), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_ena(ro_ena_b), .chan_sel(chan_sel),
        .gate_len(gate_len), .start(start), .continuous(continuous), .shift(shift),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .count(count_b), .sdo(sdo_b)
    );

    always #5 clk = ~clk;

    // Periodic ring stand-ins; period 0 holds the line low.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (per[k] == 0) begin
                ph[k] = 0;
                ro_in[k] <= 1'b0;
            end else begin
                ph[k] = (ph[k] + 1) % per[k];
                ro_in[k] <= (ph[k] < per[k] / 2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected 4-bit result for a given true edge count.
    function automatic logic [3:0] model_b(input int n);
`ifdef RO_FREQ_METER_SATURATE_EN
        return (n > 15) ? 4'd15 : 4'(n);
`else
        return 4'(n % 16);
`endif
    endfunction

    // Entered at posedge+1; returns cycles from the accepting edge to done.
    task automatic run_one(input int ch, input int g, output int lat, output logic [3:0] ena);
        chan_sel = 2'(ch);
        gate_len = 12'(g);
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ena   = ro_ena_a;
        lat   = 0;
        while (!done_a && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int         lat;
    logic [3:0] ena;
    logic [15:0] word_a;
    logic [3:0]  word_b;

    initial begin
        vecs[0] = '{ch: 2, g: 100, p: '{7, 5, 10, 3}, exp_cnt: 10, exp_lat: 103, exp_ena: 4'b0100};
        vecs[1] = '{ch: 0, g: 50,  p: '{5, 0, 10, 0}, exp_cnt: 10, exp_lat: 53,  exp_ena: 4'b0001};
        vecs[2] = '{ch: 3, g: 0,   p: '{5, 5, 10, 0}, exp_cnt: 0,  exp_lat: 4,   exp_ena: 4'b1000};
        vecs[3] = '{ch: 1, g: 100, p: '{0, 4, 0, 0},  exp_cnt: 25, exp_lat: 103, exp_ena: 4'b0010};
        vecs[4] = '{ch: 2, g: 20,  p: '{4, 4, 10, 4}, exp_cnt: 2,  exp_lat: 23,  exp_ena: 4'b0100};

        rst_n = 1'b0; chan_sel = '0; gate_len = '0;
        start = 1'b0; continuous = 1'b0; shift = 1'b0;
        #3;
        check("reset_a", {ro_ena_a, busy_a, done_a, ovf_a, count_a, sdo_a}, 32'h0);
        check("reset_b", {ro_ena_b, busy_b, done_b, ovf_b, count_b, sdo_b}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) per[k] = vecs[i].p[k];
            repeat (20) @(posedge clk);
            #1;
            run_one(vecs[i].ch, vecs[i].g, lat, ena);
            $display("vec %0d: ch=%0d gate=%0d lat=%0d count_a=%0d count_b=%0d ovf_b=%0b",
                     i, vecs[i].ch, vecs[i].g, lat, count_a, count_b, ovf_b);
            check("latency", lat, vecs[i].exp_lat);
            check("ro_ena", ena, vecs[i].exp_ena);
            check("count_a", count_a, vecs[i].exp_cnt);
            check("ovf_a", ovf_a, 0);
            check("count_b", count_b, model_b(vecs[i].exp_cnt));
            check("ovf_b", ovf_b, (vecs[i].exp_cnt > 15) ? 1 : 0);
            check("idle_busy", busy_a, 0);
            check("idle_ena", ro_ena_a, 0);
        end

        // Serial shift-out of the last result (25 edges on ch1).
        per = '{0, 4, 0, 0};
        repeat (20) @(posedge clk);
        #1;
        run_one(1, 100, lat, ena);
        word_a = 16'h0019;
        word_b = model_b(25);
        for (int i = 0; i < 18; i++) begin
            check("sdo_a", sdo_a, (i < 16) ? word_a[15 - i] : 1'b0);
            check("sdo_b", sdo_b, (i < 4) ? word_b[3 - i] : 1'b0);
            $display("shift %0d: sdo_a=%0b sdo_b=%0b", i, sdo_a, sdo_b);
            shift = 1'b1;
            @(posedge clk); #1;
            shift = 1'b0;
        end

        // Shift held through the latch edge: reload wins, MSB intact.
        per = '{0, 0, 10, 0};
        repeat (20) @(posedge clk);
        #1;
        shift = 1'b1;
        run_one(2, 100, lat, ena);
        $display("latch+shift: count_b=%0d sdo_b=%0b", count_b, sdo_b);
        check("ls_count_b", count_b, 4'd10);
        check("ls_sdo_b", sdo_b, 1'b1);
        @(posedge clk); #1;
        check("ls_sdo_b_next", sdo_b, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        check("ls_sdo_a", sdo_a, 1'b1);
        shift = 1'b0;

        // Continuous mode then drop continuous mid-window.
        continuous = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_one(2, 100, lat, ena);
        check("cont_lat", lat, 103);
        check("cont_count", count_a, 10);
        check("cont_busy", busy_a, 1);
        repeat (100) @(posedge clk);
        #1;
        check("cont_count2", count_a, 10);
        check("cont_ena", ro_ena_a, 4'b0100);
        repeat (50) @(posedge clk);
        #1 continuous = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        check("cont_busy_end", busy_a, 1);
        @(posedge clk); #1;
        $display("cont end: busy=%0b count_a=%0d ena=%b", busy_a, count_a, ro_ena_a);
        check("cont_idle", busy_a, 0);
        check("cont_count3", count_a, 10);
        check("cont_ena_off", ro_ena_a, 4'b0000);

        // Start and chan_sel pulsed during GATE must be ignored.
        per = '{0, 5, 10, 0};
        repeat (20) @(posedge clk);
        #1;
        chan_sel = 2'd2; gate_len = 12'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done_a && lat < 5000) begin
            if (lat == 50) begin
                start = 1'b1; chan_sel = 2'd1; gate_len = 12'd10;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        $display("busy protect: lat=%0d count_a=%0d", lat, count_a);
        check("prot_lat", lat, 103);
        check("prot_count", count_a, 10);

        // Asynchronous reset in the middle of a window.
        repeat (5) @(posedge clk);
        #1;
        chan_sel = 2'd2; gate_len = 12'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_a", {ro_ena_a, busy_a, done_a, ovf_a, count_a, sdo_a}, 32'h0);
        check("midrst_b", {ro_ena_b, busy_b, done_b, ovf_b, count_b, sdo_b}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", busy_a, 0);
        run_one(2, 100, lat, ena);
        $display("after reset: lat=%0d count_a=%0d", lat, count_a);
        check("post_rst_lat", lat, 103);
        check("post_rst_count", count_a, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
# ro_freq_meter

Multi-channel ring-oscillator frequency meter, the parametrised successor to the single-ring worker. It enables one of `CHANNELS` ring oscillators (already divided down to below clk/2) and synchronises its output into the `clk` domain. It counts rising edges over a programmable gate window, then presents the result in parallel and as a serial shift-out. It supports one-shot and continuous measurement modes.

## Interface

Parameters:
- `CHANNELS`, 4, number of ring inputs (1..8).
- `COUNT_W`, 16, edge counter/result width.
- `GATE_W`, 12, width of gate length.
- `SYNC_STAGES`, 2, synchroniser depth (≥2).
- Derived `SEL_W` = max(1, clog2(`CHANNELS`)).

Ports:
- `clk` in 1: sole clock; the whole block is in this domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `ro_in` in `CHANNELS`: asynchronous ring-derived signals.
- `ro_ena` out `CHANNELS`: one-hot ring enable; all zero when idle.
- `chan_sel` in `SEL_W`: channel to measure, captured at start.
- `gate_len` in `GATE_W`: window length in clk cycles, captured at start; 0 is treated as 1.
- `start` in 1: request measurement; sampled only in IDLE.
- `continuous` in 1: back-to-back windows while high.
- `shift` in 1: advance serial output by one bit.
- `busy` out 1: high in SETTLE/GATE.
- `done` out 1: sticky result-valid flag.
- `overflow` out 1: counter reached max in the last window.
- `count` out `COUNT_W`: last latched result.
- `sdo` out 1: MSB of the shift register.

## Operation

- FSM states: IDLE, SETTLE, GATE.
- IDLE:
  - `start`=1 captures `chan_sel` (≥`CHANNELS` maps to 0) and `gate_len`.
  - Clears `done`, the edge counter and the overflow accumulator.
  - Goes to SETTLE.
- SETTLE:
  - `ro_ena[sel]`=1.
  - Waits S = `SYNC_STAGES`+1 cycles to flush the synchroniser, then goes to GATE.
- GATE:
  - Edge = sync & ~prev on the selected channel; counter +1 per edge.
  - The previous-value register updates in every state, so an edge is counted only if it occurs inside the window.
  - After G = captured `gate_len` cycles, latch the result:
    - `count`<=counter, including an edge detected in the final cycle.
    - Shift register <= counter.
    - `overflow`<=accumulator.
    - `done`<=1.
  - If `continuous`=1: clear the counter and re-enter GATE with no SETTLE; the ring stays enabled.
  - Otherwise: go to IDLE and drop `ro_ena`.
- `continuous` falling mid-window: finish the window, then IDLE.
- `start` while busy: ignored.
- Changes to `chan_sel`/`gate_len` while busy: ignored until the next accepted start.
- Counter reaching 2^`COUNT_W`−1 with another edge sets the overflow accumulator. Wrap or saturate is selected per Configuration.
- Shift register:
  - `shift`=1 shifts left by one, filling with 0; `sdo` = MSB.
  - A latch in the same cycle takes priority and `shift` is dropped.
  - `shift` works in any state.

## Timing

- Reset (async assert, sync-free release): every output is 0 (`ro_ena`, `busy`, `done`, `overflow`, `count`, `sdo`); FSM goes to IDLE; synchronisers are cleared.
- Start accepted at edge T0:
  - `busy` and `ro_ena` are high from T0.
  - GATE covers edges T0+S .. T0+S+G−1.
  - `count`/`done` update at edge T0+S+G.
  - `busy` falls at the same edge in one-shot mode.
- Continuous mode: results every G cycles thereafter.
- Input-to-count latency: `SYNC_STAGES`+1 cycles; an edge arriving less than that before window end falls into the next window (or is lost in one-shot).
- Reset mid-operation aborts immediately; no partial result is latched.

## Configuration

- `RO_FREQ_METER_SATURATE_EN` defined: counter saturates at 2^`COUNT_W`−1; `overflow` set.
- Macro undefined: counter wraps modulo 2^`COUNT_W`; `overflow` is still set.

## Test plan

- Reset: assert `rst_n`=0 mid-GATE → all outputs 0 asynchronously; after release, `busy`=0, and `start` works normally.
- One-shot: `CHANNELS`=4, `chan_sel`=2, `gate_len`=100, `ro_in[2]` period 10 clk → `ro_ena`=4'b0100, `count`=10, `done` rises exactly 103 cycles after start (S=3), `overflow`=0.
- Continuous: same stimulus with `continuous`=1 → `count`=10 refreshed every 100 cycles, `ro_ena` held; drop `continuous` → one more result, then IDLE.
- Overflow: `COUNT_W`=4, `gate_len`=100, period 4 → 25 edges.
  - With macro: `count`=15, `overflow`=1.
  - Without macro: `count`=9, `overflow`=1.
- Shift-out: result 16'hA5C3, 16 `shift` pulses → `sdo` sequence 1010_0101_1100_0011, then 0s. `shift` coincident with latch → register reloads and MSB is intact.
- Busy protection: `start` and `chan_sel`=1 pulsed during GATE → no restart, channel 2 measured, `done` timing unchanged.
